// File: rtl/data_mem_pkg.sv
// data_mem_pkg -- shared types and helpers for the data_mem_pipe block.
//   addr_mode_t : the eight AddrMode access codes (loads 000..100, stores 101..111)
//   state_t     : access FSM states
//   size_mask / is_store / is_misaligned / load_extend : decode helpers
package data_mem_pkg;

    typedef enum logic [2:0] {
        AM_LB  = 3'b000,
        AM_LH  = 3'b001,
        AM_LW  = 3'b010,
        AM_LBU = 3'b011,
        AM_LHU = 3'b100,
        AM_SB  = 3'b101,
        AM_SH  = 3'b110,
        AM_SW  = 3'b111
    } addr_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT2 = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int         OFFSET_BITS = 2;
    localparam int         NUM_LANES   = 4;
    localparam logic [3:0] MASK_BYTE   = 4'b0001;
    localparam logic [3:0] MASK_HALF   = 4'b0011;
    localparam logic [3:0] MASK_WORD   = 4'b1111;

    // Byte-enable pattern of an access at offset 0.
    function automatic logic [3:0] size_mask(addr_mode_t m);
        case (m)
            AM_LB, AM_LBU, AM_SB: return MASK_BYTE;
            AM_LH, AM_LHU, AM_SH: return MASK_HALF;
            default:              return MASK_WORD;
        endcase
    endfunction

    function automatic logic is_store(addr_mode_t m);
        return (m == AM_SB) || (m == AM_SH) || (m == AM_SW);
    endfunction

    // offset mod size != 0
    function automatic logic is_misaligned(addr_mode_t m, logic [1:0] off);
        case (size_mask(m))
            MASK_HALF: return off[0];
            MASK_WORD: return |off;
            default:   return 1'b0;
        endcase
    endfunction

    // raw holds the addressed bytes right-justified, lowest address in [7:0].
    function automatic logic [31:0] load_extend(addr_mode_t m, logic [31:0] raw);
        case (m)
            AM_LB:   return {{24{raw[7]}}, raw[7:0]};
            AM_LH:   return {{16{raw[15]}}, raw[15:0]};
            AM_LBU:  return {24'b0, raw[7:0]};
            AM_LHU:  return {16'b0, raw[15:0]};
            AM_LW:   return raw;
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// data_mem_if -- request/response bus of data_mem_pipe.
//   master : requester (drives req_valid, AddrMode, A, WD)
//   slave  : memory    (drives req_ready, rsp_valid, RD, misaligned)
interface data_mem_if
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    addr_mode_t            AddrMode;
    logic [ADDR_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] WD;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] RD;
    logic                  misaligned;

    modport master (
        output req_valid, AddrMode, A, WD,
        input  req_ready, rsp_valid, RD, misaligned
    );

    modport slave (
        input  req_valid, AddrMode, A, WD,
        output req_ready, rsp_valid, RD, misaligned
    );
endinterface

// File: rtl/data_mem_bank.sv
// data_mem_bank -- word-wide RAM built from four byte lanes.
//   clk  : clock
//   addr : word index (shared by read and write)
//   we   : per-byte write enables
//   wd   : write data, byte b on wd[8b+7:8b]
//   q    : registered read data (old contents on a same-cycle write)
// Contents start at zero and are not touched by any reset.
module data_mem_bank
    import data_mem_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic                         clk,
    input  logic [AW-1:0]                addr,
    input  logic [NUM_LANES-1:0]         we,
    input  logic [NUM_LANES-1:0][7:0]    wd,
    output logic [NUM_LANES-1:0][7:0]    q
);
    localparam int DEPTH = 1 << AW;

    for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
        logic [7:0] mem [0:DEPTH-1] = '{default: 8'h00};
        logic [7:0] q_lane;

        always_ff @(posedge clk) begin
            if (we[b]) mem[addr] <= wd[b];
            q_lane <= mem[addr];
        end

        assign q[b] = q_lane;
    end
endmodule

// File: rtl/data_mem_pipe.sv
// data_mem_pipe -- byte-addressed data memory with sized, sign/zero-extending
// loads and byte-accurate stores. Accesses that straddle a word boundary take
// a second beat on the next word (wrapping at the top of memory).
//   clk : clock
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : data_mem_if.slave -- req_valid/req_ready/AddrMode/A/WD in,
//         rsp_valid/RD/misaligned out
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses are trapped
// (nothing written, misaligned=1, one-cycle response) instead of performed.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int ADDR_REAL_WIDTH = 20
) (
    input  logic      clk,
    input  logic      rst,
    data_mem_if.slave bus
);
    localparam int WORD_AW = ADDR_REAL_WIDTH - OFFSET_BITS;

    state_t               state;
    addr_mode_t           mode_in, mode_q;
    logic [WORD_AW-1:0]   idx_in, idx2_q, bank_addr;
    logic [1:0]           off_in, off_q;
    logic [7:0]           wide_be;
    logic [63:0]          wide_wd;
    logic                 cross_in, trap_in, store_in, accept;
    logic                 store_q, cross_q, trap_q;
    logic [3:0]           hi_be_q;
    logic [31:0]          hi_wd_q, lo_q;
    logic [3:0]           bank_we;
    logic [31:0]          bank_wd, bank_q;
    logic                 rsp;
    logic [63:0]          window;
    logic [31:0]          aligned;
    logic [DATA_WIDTH-1:0] rd_val;

    // Address bits above the implemented memory are ignored.
    if (ADDR_WIDTH > ADDR_REAL_WIDTH) begin : g_hi_addr
        logic unused_hi_addr;
        assign unused_hi_addr = ^bus.A[ADDR_WIDTH-1:ADDR_REAL_WIDTH];
    end

    assign mode_in  = bus.AddrMode;
    assign idx_in   = bus.A[ADDR_REAL_WIDTH-1:OFFSET_BITS];
    assign off_in   = bus.A[1:0];
    assign store_in = is_store(mode_in);

    // Bytes/data laid out across two consecutive words; the upper half is
    // what the second beat touches, so any bit set there means a crossing.
    assign wide_be  = {4'b0, size_mask(mode_in)} << off_in;
    assign wide_wd  = {32'b0, bus.WD} << {off_in, 3'b000};
    assign cross_in = |wide_be[7:4];

`ifdef MISALIGN_TRAP_EN
    assign trap_in = is_misaligned(mode_in, off_in);
`else
    assign trap_in = 1'b0;
`endif

    assign bus.req_ready = (state == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    // Beat 1 uses the incoming address on the acceptance cycle; beat 2 uses
    // the saved next word. A reset during BEAT2 suppresses its write.
    always_comb begin
        bank_addr = idx_in;
        bank_wd   = wide_wd[31:0];
        bank_we   = '0;
        if (state == ST_BEAT2) begin
            bank_addr = idx2_q;
            bank_wd   = hi_wd_q;
            if (store_q && !rst) bank_we = hi_be_q;
        end else if (accept && store_in && !trap_in) begin
            bank_we = wide_be[3:0];
        end
    end

    data_mem_bank #(.AW(WORD_AW)) u_bank (
        .clk  (clk),
        .addr (bank_addr),
        .we   (bank_we),
        .wd   (bank_wd),
        .q    (bank_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_q  <= AM_LB;
            off_q   <= '0;
            store_q <= 1'b0;
            cross_q <= 1'b0;
            trap_q  <= 1'b0;
            idx2_q  <= '0;
            hi_be_q <= '0;
            hi_wd_q <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q  <= mode_in;
                        off_q   <= off_in;
                        store_q <= store_in;
                        trap_q  <= trap_in;
                        cross_q <= cross_in && !trap_in;
                        idx2_q  <= idx_in + WORD_AW'(1);  // wraps to word 0
                        hi_be_q <= wide_be[7:4];
                        hi_wd_q <= wide_wd[63:32];
                        state   <= (cross_in && !trap_in) ? ST_BEAT2 : ST_RESP;
                    end
                end
                ST_BEAT2: begin
                    lo_q  <= bank_q;  // first word's read data lands here
                    state <= ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // In RESP the bank output holds the last word read; for a crossing load
    // it is the upper word and lo_q the lower one.
    always_comb begin
        window  = cross_q ? {bank_q, lo_q} : {32'b0, bank_q};
        aligned = 32'(window >> {off_q, 3'b000});
        rd_val  = load_extend(mode_q, aligned);
    end

    assign rsp           = (state == ST_RESP) && !rst;
    assign bus.rsp_valid = rsp;
    assign bus.RD        = (rsp && !store_q && !trap_q) ? rd_val : '0;
`ifdef MISALIGN_TRAP_EN
    assign bus.misaligned = rsp && trap_q;
`else
    assign bus.misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe -- directed, table-driven bench for data_mem_pipe.
module tb_data_mem_pipe;
    import data_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    data_mem_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ADDR_REAL_WIDTH(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        addr_mode_t  mode;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, hold it until accepted, then wait (bounded) for the
    // response. lat counts cycles after the acceptance edge; 99 = no response.
    task automatic access(input addr_mode_t mode, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic mis, output int lat);
        int guard;
        bus.req_valid = 1'b1;
        bus.AddrMode  = mode;
        bus.A         = addr;
        bus.WD        = wd;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = bus.RD;
        mis = bus.misaligned;
        if (!bus.rsp_valid) lat = 99;
    endtask

    task automatic run(input string name, input addr_mode_t mode, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat,
                       input logic exp_mis);
        logic [31:0] rd;
        logic        mis;
        int          lat;
        access(mode, addr, wd, rd, mis, lat);
        check({name, ".rd"}, rd, exp_rd);
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".mis"}, {31'b0, mis}, {31'b0, exp_mis});
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.AddrMode  = AM_LW;
        bus.A         = '0;
        bus.WD        = '0;

        // Aligned accesses: same expectations with or without the trap option.
        vecs.push_back('{AM_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1});
        vecs.push_back('{AM_LW,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1});
        vecs.push_back('{AM_LB,  32'h0000_0103, 32'h0,         32'hFFFF_FFDE, 1});
        vecs.push_back('{AM_LBU, 32'h0000_0103, 32'h0,         32'h0000_00DE, 1});
        vecs.push_back('{AM_LHU, 32'h0000_0102, 32'h0,         32'h0000_DEAD, 1});
        vecs.push_back('{AM_LH,  32'h0000_0102, 32'h0,         32'hFFFF_DEAD, 1});
        vecs.push_back('{AM_LB,  32'h0000_0100, 32'h0,         32'hFFFF_FFEF, 1});
        vecs.push_back('{AM_LBU, 32'h0000_0101, 32'h0,         32'h0000_00BE, 1});
        vecs.push_back('{AM_SB,  32'h0000_0104, 32'h1234_5680, 32'h0000_0000, 1});
        vecs.push_back('{AM_LW,  32'h0000_0104, 32'h0,         32'h0000_0080, 1});
        vecs.push_back('{AM_LB,  32'h0000_0104, 32'h0,         32'hFFFF_FF80, 1});
        vecs.push_back('{AM_SH,  32'h0000_0106, 32'hFFFF_7F01, 32'h0000_0000, 1});
        vecs.push_back('{AM_LW,  32'h0000_0104, 32'h0,         32'h7F01_0080, 1});
        vecs.push_back('{AM_LHU, 32'h0000_0106, 32'h0,         32'h0000_7F01, 1});
        vecs.push_back('{AM_LW,  32'hABC0_0100, 32'h0,         32'hDEAD_BEEF, 1});
        vecs.push_back('{AM_LW,  32'h0000_0300, 32'h0,         32'h0000_0000, 1});

        // Reset: a request held during reset must not be taken.
        bus.req_valid = 1'b1;
        bus.AddrMode  = AM_SW;
        bus.A         = 32'h0000_0300;
        bus.WD        = 32'h5A5A_5A5A;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", {31'b0, bus.req_ready}, 32'h0);
        check("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        check("rst.RD", bus.RD, 32'h0);
        check("rst.misaligned", {31'b0, bus.misaligned}, 32'h0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("post_rst.req_ready", {31'b0, bus.req_ready}, 32'h1);

        foreach (vecs[i])
            run($sformatf("vec%0d", i), vecs[i].mode, vecs[i].addr, vecs[i].wd,
                vecs[i].exp_rd, vecs[i].exp_lat, 1'b0);

`ifndef MISALIGN_TRAP_EN
        // Word-crossing accesses take a second beat.
        run("sw_cross",   AM_SW,  32'h0000_01FE, 32'h1122_3344, 32'h0,         2, 1'b0);
        run("lw_cross",   AM_LW,  32'h0000_01FE, 32'h0,         32'h1122_3344, 2, 1'b0);
        run("lbu_200",    AM_LBU, 32'h0000_0200, 32'h0,         32'h0000_0022, 1, 1'b0);
        run("lh_cross",   AM_LH,  32'h0000_01FF, 32'h0,         32'h0000_2233, 2, 1'b0);
        run("lw_1fc",     AM_LW,  32'h0000_01FC, 32'h0,         32'h3344_0000, 1, 1'b0);
        // Crossing at the top of memory wraps to word 0.
        run("sw_wrap",    AM_SW,  32'h000F_FFFE, 32'hCAFE_F00D, 32'h0,         2, 1'b0);
        run("lbu_wrap0",  AM_LBU, 32'h0000_0000, 32'h0,         32'h0000_00FE, 1, 1'b0);
        run("lbu_wrap1",  AM_LBU, 32'h0000_0001, 32'h0,         32'h0000_00CA, 1, 1'b0);
        run("lhu_wrap",   AM_LHU, 32'h000F_FFFF, 32'h0,         32'h0000_FEF0, 2, 1'b0);
        run("lh_wrap",    AM_LH,  32'h000F_FFFF, 32'h0,         32'hFFFF_FEF0, 2, 1'b0);

        // Reset while in BEAT2: no response, first beat bytes stay written.
        begin
            int guard;
            bus.req_valid = 1'b1;
            bus.AddrMode  = AM_SW;
            bus.A         = 32'h000F_FFFE;
            bus.WD        = 32'h5566_7788;
            guard = 0;
            @(negedge clk);
            while (!bus.req_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            rst = 1'b1;
            check("beat2_rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            check("beat2_rst.req_ready", {31'b0, bus.req_ready}, 32'h1);
            for (int c = 0; c < 3; c++) begin
                check($sformatf("beat2_rst.quiet%0d", c), {31'b0, bus.rsp_valid}, 32'h0);
                @(posedge clk);
                #1;
            end
        end
        run("abandon_b0",  AM_LBU, 32'h0000_0000, 32'h0, 32'h0000_00FE, 1, 1'b0);
        run("kept_fffe",   AM_LBU, 32'h000F_FFFE, 32'h0, 32'h0000_0088, 1, 1'b0);
        run("kept_ffff",   AM_LBU, 32'h000F_FFFF, 32'h0, 32'h0000_0077, 1, 1'b0);
`else
        // Misaligned accesses trap: one-cycle response, nothing written.
        run("sh_trap",     AM_SH,  32'h0000_0101, 32'h0000_AAAA, 32'h0, 1, 1'b1);
        run("lw_after",    AM_LW,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
        run("sw_trap",     AM_SW,  32'h0000_01FE, 32'h1122_3344, 32'h0, 1, 1'b1);
        run("lw_trap",     AM_LW,  32'h0000_0101, 32'h0, 32'h0, 1, 1'b1);
        run("lw_1fc",      AM_LW,  32'h0000_01FC, 32'h0, 32'h0, 1, 1'b0);
        run("lw_200",      AM_LW,  32'h0000_0200, 32'h0, 32'h0, 1, 1'b0);
`endif

        // Response is a single-cycle pulse.
        @(posedge clk);
        #1;
        check("pulse_end", {31'b0, bus.rsp_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL be the access word width; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL be the width of the byte address input.
REQ-003 Parameter ADDR_REAL_WIDTH, default 20, SHALL set the memory size to 2**ADDR_REAL_WIDTH bytes.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 req_valid  input  1  SHALL flag a request on this cycle.
REQ-007 req_ready  output  1  SHALL flag that a request is accepted this cycle.
REQ-008 AddrMode  input  3  SHALL select the access: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-009 A  input  ADDR_WIDTH  SHALL be the byte address.
REQ-010 WD  input  DATA_WIDTH  SHALL be the store data, right-justified.
REQ-011 rsp_valid  output  1  SHALL pulse high for one cycle per completed access.
REQ-012 RD  output  DATA_WIDTH  SHALL be the load result, valid only while rsp_valid is high.
REQ-013 misaligned  output  1  SHALL flag a trapped misaligned access, valid only while rsp_valid is high.

Function
REQ-014 A request SHALL be accepted on a cycle where req_valid and req_ready are both high; req_ready SHALL be high only in state IDLE.
REQ-015 Address bits above ADDR_REAL_WIDTH-1 SHALL be ignored; word index = A[ADDR_REAL_WIDTH-1:2], byte offset = A[1:0].
REQ-016 Storage SHALL be word-organised with four byte-write enables; writes SHALL be synchronous, never combinational.
REQ-017 FSM states SHALL be IDLE, BEAT2, RESP; an access not crossing a word boundary goes IDLE->RESP, and a crossing access goes IDLE->BEAT2->RESP; RESP->IDLE unconditionally.
REQ-018 An access SHALL cross a word boundary when offset + size > 4 (size 1/2/4 bytes).
REQ-019 rsp_valid SHALL rise 1 cycle after acceptance for non-crossing accesses and 2 cycles after for crossing ones.
REQ-020 The second beat SHALL use word index+1, wrapping from the last word to word 0.
REQ-021 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits; the byte at the lowest address SHALL be least significant (little-endian).
REQ-022 Stores SHALL write exactly the addressed bytes, the first beat's bytes on acceptance and the remainder in BEAT2; RD SHALL be 0 for stores.
REQ-023 A load of bytes written by a store whose rsp_valid has already pulsed SHALL return the new data.
REQ-024 req_valid while the block is busy SHALL be ignored and not queued; the requester holds it until req_ready.

Reset
REQ-025 While rst is high: state SHALL go to IDLE, and rsp_valid, RD, misaligned SHALL be 0; req_ready SHALL be 0 in the reset cycle.
REQ-026 Reset in BEAT2 SHALL abandon the second beat without a response; bytes committed by the first beat SHALL persist.
REQ-027 Memory contents SHALL NOT be cleared by rst; they SHALL be zero at elaboration.

Configuration
REQ-028 With MISALIGN_TRAP_EN defined, an access where offset mod size != 0 SHALL write nothing and SHALL respond after 1 cycle with misaligned=1 and RD=0; BEAT2 SHALL be unreachable.
REQ-029 Without MISALIGN_TRAP_EN, misaligned accesses SHALL complete per REQ-017..REQ-022, and misaligned SHALL be tied to 0.

Structure
REQ-030 Package data_mem_pkg SHALL hold the addr_mode_t enum (the eight AddrMode codes), the state_t enum and size/offset helper constants.
REQ-031 Sub-module data_mem_bank SHALL implement one word-wide RAM with four byte-write enables and a registered read port.

Verification
REQ-032 SW A=0x100 WD=0xDEADBEEF, then LW A=0x100 -> each rsp_valid 1 cycle after acceptance, RD=0xDEADBEEF.
REQ-033 After REQ-032: LB A=0x103 -> RD=0xFFFFFFDE; LBU A=0x103 -> RD=0x000000DE; LHU A=0x102 -> RD=0x0000DEAD.
REQ-034 Without MISALIGN_TRAP_EN: SW A=0x1FE WD=0x11223344, then LW A=0x1FE -> each response 2 cycles after acceptance, RD=0x11223344, byte 0x200 = 0x22.
REQ-035 With MISALIGN_TRAP_EN: SH A=0x101 WD=0xAAAA -> misaligned=1 after 1 cycle, and a following LW A=0x100 returns 0xDEADBEEF unchanged.
REQ-036 Wrap: SW A=0xFFFFE WD=0xCAFEF00D without the macro -> byte 0x00000=0xFE, byte 0x00001=0xCA; assert rst during BEAT2 of a repeat -> no rsp_valid, and req_ready high the cycle after rst drops.
